// File: rtl/wol_pkg.sv
// Shared types and constants for the Wake-on-LAN magic-packet detector.
// Latency: n/a (types/functions only); backpressure: n/a.
package wol_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_HUNT  = 3'd2,
        S_MATCH = 3'd3,
        S_PWD   = 3'd4,
        S_CAND  = 3'd5
    } wol_state_t;

    localparam int MAC_BYTES = 6;
    localparam int HDR_BYTES = 12;
    localparam int SYNC_LEN  = 6;
    localparam int PWD_BYTES = 6;

    // Byte k of a 48-bit word, k=0 being the most significant (first on the wire).
    function automatic logic [7:0] get_byte(input logic [47:0] w, input logic [2:0] k);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < MAC_BYTES; i++) begin
            if (k == 3'(i)) b = w[8*(MAC_BYTES-1-i) +: 8];
        end
        return b;
    endfunction

endpackage

// File: rtl/wol_slot_cmp.sv
// Per-slot address comparator: alive bit plus a registered expected-byte mux.
// Latency: hit is combinational against exp_q; backpressure: none, holds when no strobe.
module wol_slot_cmp
    import wol_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] addr,
    input  logic        addr_vld,
    input  logic [7:0]  rx_byte,
    input  logic [2:0]  byte_idx,
    input  logic        start,
    input  logic        step,
    input  logic        kill,
    input  logic        rewind,
    output logic        alive,
    output logic        hit
);

    logic [7:0] exp_q;
    logic [2:0] idx_nxt;

    assign hit     = (rx_byte == exp_q);
    assign idx_nxt = (byte_idx == 3'(MAC_BYTES-1)) ? 3'd0 : byte_idx + 3'd1;

    // exp_q always holds the byte the next accepted rx byte must equal.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alive <= 1'b0;
            exp_q <= '0;
        end else begin
            if (kill)       alive <= 1'b0;
            else if (start) alive <= addr_vld & hit;
            else if (step)  alive <= alive & hit;

            if (start)       exp_q <= get_byte(addr, 3'd1);
            else if (step)   exp_q <= get_byte(addr, idx_nxt);
            else if (rewind) exp_q <= get_byte(addr, 3'd0);
        end
    end

endmodule

// File: rtl/wol_magic_detect_multi.sv
// Multi-slot Wake-on-LAN magic-packet detector with optional SecureOn password.
// Latency: wake/wake_pulse one clock after rx_end; backpressure: none, rx_en=0 holds parser state.
module wol_magic_detect_multi
    import wol_pkg::*;
#(
    parameter int NUM_ADDR = 2,
    parameter int REPEAT   = 16,
    parameter int PWD_EN   = 1
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       rx_en,
    input  logic                                       rx_dv,
    input  logic [7:0]                                 rx_data,
    input  logic                                       rx_end,
    input  logic                                       rx_crc_ok,
    input  logic                                       rx_err,
    input  logic                                       rx_addr_ok,
    input  logic                                       cfg_wol_en,
    input  logic [48*NUM_ADDR-1:0]                     cfg_addr,
    input  logic [NUM_ADDR-1:0]                        cfg_addr_vld,
    input  logic                                       cfg_pwd_en,
    input  logic [47:0]                                cfg_pwd,
    input  logic                                       wake_clr,
    output logic                                       wake,
    output logic [(NUM_ADDR>1?$clog2(NUM_ADDR):1)-1:0] wake_slot,
    output logic                                       wake_pulse
);

    localparam int SLOT_W = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;
    localparam int REP_W  = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    wol_state_t        state;
    logic [2:0]        ff_cnt;
    logic [3:0]        hdr_cnt;
    logic [2:0]        byte_idx;
    logic [REP_W-1:0]  rep_cnt;
    logic [SLOT_W-1:0] cand_slot;
    logic              dv_q;

    logic [NUM_ADDR-1:0] alive, hit, alive_nxt;
    logic rx_rise, kill, go, start, step, rewind, is_ff;
    logic last_byte, last_rep, pwd_req, pwd_hit, wake_set;

    function automatic logic [SLOT_W-1:0] lowest(input logic [NUM_ADDR-1:0] v);
        logic [SLOT_W-1:0] s;
        s = '0;
        for (int i = NUM_ADDR-1; i >= 0; i--) begin
            if (v[i]) s = SLOT_W'(i);
        end
        return s;
    endfunction

    assign rx_rise   = rx_en & rx_dv & ~dv_q;
    assign kill      = ~cfg_wol_en | rx_end | rx_rise;
    assign go        = rx_en & ~kill;
    assign is_ff     = (rx_data == 8'hFF);
    assign start     = go & (state == S_HUNT) & ~is_ff & (ff_cnt == 3'(SYNC_LEN));
    assign step      = go & (state == S_MATCH);
    assign rewind    = (state != S_MATCH);
    assign alive_nxt = alive & hit;
    assign last_byte = (byte_idx == 3'(MAC_BYTES-1));
    assign last_rep  = (rep_cnt == REP_W'(REPEAT-1));
    assign pwd_req   = (PWD_EN != 0) & cfg_pwd_en;
    assign pwd_hit   = (rx_data == get_byte(cfg_pwd, byte_idx));
    assign wake_set  = rx_end & (state == S_CAND) & cfg_wol_en & rx_crc_ok & ~rx_err & rx_addr_ok;

    for (genvar g = 0; g < NUM_ADDR; g++) begin : g_slot
        wol_slot_cmp u_cmp (
            .clk      (clk),
            .rst_n    (rst_n),
            .addr     (cfg_addr[48*g +: 48]),
            .addr_vld (cfg_addr_vld[g]),
            .rx_byte  (rx_data),
            .byte_idx (byte_idx),
            .start    (start),
            .step     (step),
            .kill     (kill),
            .rewind   (rewind),
            .alive    (alive[g]),
            .hit      (hit[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ff_cnt     <= '0;
            hdr_cnt    <= '0;
            byte_idx   <= '0;
            rep_cnt    <= '0;
            cand_slot  <= '0;
            // A frame already in flight at reset must not look like a fresh rx_dv edge.
            dv_q       <= 1'b1;
            wake       <= 1'b0;
            wake_slot  <= '0;
            wake_pulse <= 1'b0;
        end else begin
            wake_pulse <= 1'b0;
            if (rx_en) dv_q <= rx_dv;

            if (wake_set) begin
                wake       <= 1'b1;
                wake_slot  <= cand_slot;
                wake_pulse <= 1'b1;
            end else if (wake_clr || !cfg_wol_en) begin
                wake <= 1'b0;
            end

            if (!cfg_wol_en || rx_end) begin
                state    <= S_IDLE;
                ff_cnt   <= '0;
                hdr_cnt  <= '0;
                byte_idx <= '0;
                rep_cnt  <= '0;
            end else if (rx_rise) begin
                state    <= S_HDR;
                hdr_cnt  <= 4'd1;
                ff_cnt   <= '0;
                byte_idx <= '0;
                rep_cnt  <= '0;
            end else if (rx_en) begin
                case (state)
                    S_IDLE: ;
                    S_HDR: begin
                        if (hdr_cnt == 4'(HDR_BYTES-1)) begin
                            state  <= S_HUNT;
                            ff_cnt <= '0;
                        end else begin
                            hdr_cnt <= hdr_cnt + 4'd1;
                        end
                    end
                    S_HUNT: begin
                        if (is_ff) begin
                            if (ff_cnt != 3'(SYNC_LEN)) ff_cnt <= ff_cnt + 3'd1;
                        end else if (ff_cnt == 3'(SYNC_LEN)) begin
                            state    <= S_MATCH;
                            byte_idx <= 3'd1;
                            rep_cnt  <= '0;
                        end else begin
                            ff_cnt <= '0;
                        end
                    end
                    S_MATCH: begin
                        if (alive_nxt == '0) begin
                            state  <= S_HUNT;
                            ff_cnt <= {2'b00, is_ff};
                        end else if (last_byte) begin
                            byte_idx <= '0;
                            if (last_rep) begin
                                if (pwd_req) begin
                                    state <= S_PWD;
                                end else begin
                                    state     <= S_CAND;
                                    cand_slot <= lowest(alive_nxt);
                                end
                            end else begin
                                rep_cnt <= rep_cnt + 1'b1;
                            end
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                        end
                    end
                    S_PWD: begin
                        if (!pwd_hit) begin
                            state  <= S_HUNT;
                            ff_cnt <= {2'b00, is_ff};
                        end else if (byte_idx == 3'(PWD_BYTES-1)) begin
                            state     <= S_CAND;
                            cand_slot <= lowest(alive);
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                        end
                    end
                    S_CAND: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/wol_magic_detect_multi.md
# wol_magic_detect_multi

Parametrised Wake-on-LAN magic-packet detector for the receive path of the tri-speed MAC. It watches the post-SFD receive byte stream and checks for the sync run followed by REPEAT copies of any one of NUM_ADDR programmed station addresses, optionally followed by a SecureOn password. It raises a latched wake indication, plus the index of the matching slot, only when the frame ends with good CRC and passed the address filter. It sits beside the receive address filter, in the receive clock domain, and is gated by the same byte enable.

## Interface
- NUM_ADDR, 2: number of station-address slots, 1..4.
- REPEAT, 16: required address repetitions, 2..16.
- PWD_EN, 1: 1 instantiates SecureOn password checking; 0 removes the PWD state and its logic.
- clk  in  1  receive clock.
- rst_n  in  1  synchronous, active-low reset.
- rx_en  in  1  byte enable; all byte-stream activity is qualified by it.
- rx_dv  in  1  frame-active; a rising edge (qualified by rx_en) marks the first byte after SFD.
- rx_data  in  8  receive byte.
- rx_end  in  1  one-cycle end-of-frame strobe; not qualified by rx_en.
- rx_crc_ok  in  1  FCS good; valid with rx_end.
- rx_err  in  1  PHY error seen in frame; valid with rx_end.
- rx_addr_ok  in  1  address-filter pass (unicast, multicast or broadcast accepted); valid with rx_end.
- cfg_wol_en  in  1  detector enable.
- cfg_addr  in  48*NUM_ADDR  slot i occupies [48i+47:48i], most significant byte transmitted first.
- cfg_addr_vld  in  NUM_ADDR  per-slot enable.
- cfg_pwd_en  in  1  require the 6-byte password (ignored if PWD_EN=0).
- cfg_pwd  in  48  password, most significant byte first.
- wake_clr  in  1  clears wake.
- wake  out  1  latched wake request; reset 0.
- wake_slot  out  max(1,$clog2(NUM_ADDR))  slot that matched; reset 0; held with wake.
- wake_pulse  out  1  one-cycle strobe when wake sets; reset 0.

## Operation
- States: IDLE, HDR, HUNT, MATCH, PWD, CAND.
- IDLE: on rx_en & rising rx_dv, byte 0 is consumed and the state goes to HDR with hdr_cnt=1.
- HDR: skip 12 bytes (DA+SA). The 12th byte moves to HUNT with ff_cnt=0.
- HUNT: an FF byte increments ff_cnt, saturating at 6. Any other byte:
  - with ff_cnt==6: goes to MATCH; this byte is rep 0, byte 0; every slot with cfg_addr_vld set is marked alive if this byte equals its first byte.
  - otherwise: clears ff_cnt.
  - Extra FF bytes beyond 6 are tolerated. Slots whose first byte is FF are therefore unsupported; the document records that as a configuration rule.
- MATCH: byte index 0..5 and rep counter 0..REPEAT-1. Each byte clears the alive bit of every slot whose corresponding byte differs.
  - If no slot remains alive: return to HUNT, with ff_cnt=1 if the byte is FF, else 0.
  - After byte 5 of rep REPEAT-1 with at least one slot alive: go to PWD if PWD_EN & cfg_pwd_en, else to CAND.
- PWD: 6 bytes compared with cfg_pwd. Any mismatch goes to HUNT, using the same FF rule as MATCH. All 6 equal goes to CAND.
- CAND: ignore the remaining bytes. cand_slot = the lowest-indexed alive slot, frozen on entry.
- rx_end in any state: evaluate the frame, then go to IDLE.
  - Wake sets when the state is CAND and cfg_wol_en & rx_crc_ok & ~rx_err & rx_addr_ok all hold.
  - On set: wake_slot <= cand_slot and wake_pulse asserts.
- rx_dv rising while not IDLE (missing rx_end) restarts at HDR and discards the partial match.
- wake clears on wake_clr or ~cfg_wol_en. If a set and wake_clr land in the same cycle, the set wins.
- cfg_wol_en=0 also holds the parser in IDLE.
- Arithmetic:
  - ff_cnt is 3 bits.
  - hdr_cnt is 4 bits.
  - rep counter is $clog2(REPEAT) bits, with a terminal compare against REPEAT-1 (no wrap).
  - byte index is 3 bits, wraps 5→0.

## Timing
- All outputs are registered.
- wake and wake_pulse assert on the clock edge after the cycle that carries rx_end; wake_pulse is high for exactly one cycle.
- Byte compare is single-cycle against a registered per-slot byte mux; no pipeline bubbles.
- Reset (rst_n sampled low) mid-frame: state goes to IDLE, all counters and alive bits clear, wake, wake_slot and wake_pulse go to 0. The first frame detectable after reset is the next rising edge of rx_dv.
- Cycles where rx_en=0 hold all parser state.

## Structure
- Package wol_pkg holds:
  - the state enum;
  - MAC_BYTES=6, HDR_BYTES=12, SYNC_LEN=6, PWD_BYTES=6;
  - a byte-select function that extracts byte k (MSB first) from a 48-bit word.
- Sub-module wol_slot_cmp, one instance per slot via generate:
  - holds the alive bit;
  - takes the byte index, the rx byte, the address and control strobes (start, step, kill);
  - outputs alive.
- The top level keeps the FSM, the counters and the priority encoder for the lowest alive slot.

## Test plan
- NUM_ADDR=2; slot1 = 00:11:22:33:44:55 valid; frame = 12 header bytes + 6×FF + 16× slot1 + CRC ok, addr ok → wake=1 and wake_slot=1 one cycle after rx_end, wake_pulse single cycle.
- Same frame with only 15 repetitions, or rx_crc_ok=0 → wake stays 0.
- 9×FF before the repetitions, plus a broken first attempt (rep 3 byte 2 corrupted, then FF×6 and 16 good reps) → wake=1.
- Both slots valid with identical addresses → wake_slot=0.
- PWD_EN=1, cfg_pwd_en=1, cfg_pwd=AA..FF:
  - correct password → wake=1;
  - last password byte 0xFE → wake=0.
- Two back-to-back cases:
  - wake_clr in the same cycle as a new set → wake stays 1 and wake_pulse fires;
  - rst_n low during rep 8 → outputs 0, and the next good frame wakes.
